// File: rtl/bp_me_addr_to_cce_id_pipe.sv
// Two-stage pipelined physical-address to CCE-ID mapper with a valid/ready
// request side, a valid/yumi result side and runtime-programmable striping.
module bp_me_addr_to_cce_id_pipe #(
  parameter int paddr_width_p = 40,
  parameter int cce_id_width_p = 7,
  parameter int num_cce_p = 4,
  parameter int io_base_id_p = 8,
  parameter int lg_num_io_p = 0,
  parameter int did_width_p = 3,
  parameter logic [paddr_width_p-1:0] dram_base_p = 40'h00_8000_0000,
  parameter logic [paddr_width_p-1:0] coproc_base_p = 40'h04_0000_0000,
  parameter int dev_offset_p = 20,
  parameter int cce_offset_p = 24,
  parameter int host_dev_p = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cfg_w_v_i,
  input  logic                      cfg_addr_i,
  input  logic [15:0]               cfg_data_i,
  input  logic                      paddr_v_i,
  input  logic [paddr_width_p-1:0]  paddr_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [cce_id_width_p-1:0] cce_id_o,
  output logic                      err_o,
  output logic [paddr_width_p-1:0]  paddr_o,
  input  logic                      yumi_i
);

  localparam logic [cce_id_width_p-1:0] io_mask_lp = cce_id_width_p'((1 << lg_num_io_p) - 1);
  localparam logic [cce_id_width_p-1:0] io_base_lp = cce_id_width_p'(io_base_id_p);

  logic [3:0] stripe_shift_r;
  logic       acc_en_r;
  logic [2:0] acc_lg_r;
  logic [6:0] acc_base_r;

  logic [3:0] shift_wr;
  logic [2:0] acc_lg_wr;

  logic                      s1_v, s2_v, s1_advance, accept;
  logic [paddr_width_p-1:0]  s1_paddr;
  logic [cce_id_width_p-1:0] s1_id;
  logic                      s1_err, s1_is_dram;
  logic [15:0]               s1_slice;

  logic                      is_ext, is_host, below_dram, below_coproc;
  logic [6:0]                acc_mask, acc_sum;
  logic [cce_id_width_p-1:0] io_id, s1_id_n;
  logic                      s1_err_n, s1_is_dram_n;
  logic [15:0]               slice_mod;

  // Out-of-range writes clamp rather than wrap so a bad shift can never
  // select address bits outside the line/page window.
  assign shift_wr  = (cfg_data_i[3:0] < 4'd6)  ? 4'd6  :
                     (cfg_data_i[3:0] > 4'd12) ? 4'd12 : cfg_data_i[3:0];
  assign acc_lg_wr = (cfg_data_i[10:8] > 3'd4) ? 3'd4 : cfg_data_i[10:8];

  assign s1_advance = ~s2_v | yumi_i;
  assign ready_o    = ~s1_v | s1_advance;
  assign accept     = paddr_v_i & ready_o;

  assign is_ext       = paddr_i[paddr_width_p-1 -: did_width_p] != '0;
  assign below_dram   = paddr_i < dram_base_p;
  assign below_coproc = paddr_i < coproc_base_p;
  assign is_host      = below_dram && (paddr_i[dev_offset_p +: 4] == 4'(host_dev_p));

  assign io_id    = io_base_lp + (cce_id_width_p'(paddr_i >> 12) & io_mask_lp);
  assign acc_mask = 7'((1 << acc_lg_r) - 1);
  assign acc_sum  = acc_base_r + (7'(paddr_i >> stripe_shift_r) & acc_mask);

  // NOTE: every output of an always_comb gets a default up front; a missed
  // branch would otherwise infer a latch.
  always_comb begin
    s1_id_n      = '0;
    s1_err_n     = 1'b0;
    s1_is_dram_n = 1'b0;
    if (is_ext || is_host)
      s1_id_n = io_id;
    else if (below_dram)
      s1_id_n = paddr_i[cce_offset_p +: cce_id_width_p];
    else if (below_coproc)
      s1_is_dram_n = 1'b1;
    else if (acc_en_r)
      s1_id_n = cce_id_width_p'(acc_sum);
    else
      s1_err_n = 1'b1;
  end

  // Divisor is a parameter, so this reduces to constant-divisor logic.
  assign slice_mod = s1_slice % 16'(num_cce_p);

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values, which is what makes same-cycle config writes
  // invisible to the request accepted alongside them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stripe_shift_r <= 4'd6;
      acc_en_r       <= 1'b0;
      acc_lg_r       <= '0;
      acc_base_r     <= '0;
    end else if (cfg_w_v_i) begin
      if (!cfg_addr_i) begin
        stripe_shift_r <= shift_wr;
      end else begin
        acc_en_r   <= cfg_data_i[15];
        acc_lg_r   <= acc_lg_wr;
        acc_base_r <= cfg_data_i[6:0];
      end
    end
  end

  // NOTE: datapath registers are reset too, because the result outputs are
  // observable and must read zero after reset, not just be qualified by v_o.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_v       <= 1'b0;
      s1_paddr   <= '0;
      s1_id      <= '0;
      s1_err     <= 1'b0;
      s1_is_dram <= 1'b0;
      s1_slice   <= '0;
    end else if (ready_o) begin
      s1_v <= accept;
      if (accept) begin
        s1_paddr   <= paddr_i;
        s1_id      <= s1_id_n;
        s1_err     <= s1_err_n;
        s1_is_dram <= s1_is_dram_n;
        s1_slice   <= 16'(paddr_i >> stripe_shift_r);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_v     <= 1'b0;
      paddr_o  <= '0;
      cce_id_o <= '0;
      err_o    <= 1'b0;
    end else if (s1_advance) begin
      s2_v <= s1_v;
      if (s1_v) begin
        paddr_o  <= s1_paddr;
        cce_id_o <= s1_is_dram ? cce_id_width_p'(slice_mod) : s1_id;
        err_o    <= s1_err;
      end
    end
  end

  assign v_o = s2_v;

endmodule

// File: doc/bp_me_addr_to_cce_id_pipe.md
# bp_me_addr_to_cce_id_pipe

Pipelined, runtime-configurable successor to the combinational address-to-CCE-ID mapper in the memory-endpoint wormhole path. Accepts physical addresses over a valid/ready handshake, classifies each into external-I/O, local/host, DRAM or coprocessor region, and returns the destination CCE ID plus an error flag two cycles later. Adds software-programmable stripe granularity, coprocessor-region striping and non-power-of-two CCE counts.

## Interface
- paddr_width_p, 40, physical address width
- cce_id_width_p, 7, CCE ID width
- num_cce_p, 4, coherent CCEs (any value ≥1, not required to be a power of two)
- io_base_id_p, 8, first I/O CCE ID
- lg_num_io_p, 0, log2 of I/O CCEs (I/O striped by 4 KiB page)
- did_width_p, 3, domain-ID field width at paddr[MSBs]
- dram_base_p, 40'h00_8000_0000, first DRAM byte
- coproc_base_p, 40'h04_0000_0000, first coprocessor byte
- dev_offset_p, 20, bit offset of 4-bit device field in local addresses
- cce_offset_p, 24, bit offset of cce_id_width_p-bit CCE field in local addresses
- host_dev_p, 1, host device number
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- cfg_w_v_i  in  1  config write strobe
- cfg_addr_i  in  1  0 = stripe shift, 1 = coprocessor map
- cfg_data_i  in  16  config write data
- paddr_v_i  in  1  request valid
- paddr_i  in  paddr_width_p  request address
- ready_o  out  1  request accepted when paddr_v_i & ready_o
- v_o  out  1  result valid
- cce_id_o  out  cce_id_width_p  destination CCE
- err_o  out  1  address mapped to disabled coprocessor region
- paddr_o  out  paddr_width_p  address passed through with result
- yumi_i  in  1  consumer takes result; legal only when v_o

## Operation
- Config reg 0: stripe_shift[3:0], legal 6..12, reset 6 (64 B line); writes outside 6..12 clamp to nearest bound.
- Config reg 1: acc_en[15], lg_num_acc[10:8] (0..4), acc_base_id[6:0]; reset acc_en=0, lg=0, base=0.
- Config writes land at end of cycle; requests accepted same cycle use old values. In-flight requests keep config captured at acceptance.
- Region priority (stage 1): ext = did field ≠0; host = paddr<dram_base_p & dev==host_dev_p; local = paddr<dram_base_p; dram = paddr<coproc_base_p; else coproc.
- ext or host: io_base_id_p + paddr[12 +: lg_num_io_p] (io_base_id_p when lg=0).
- local: paddr[cce_offset_p +: cce_id_width_p].
- coproc, acc_en=1: acc_base_id + paddr[stripe_shift +: lg_num_acc], sum truncated to cce_id_width_p; acc_en=0: ID 0, err_o=1.
- dram: stage 1 registers slice = (paddr >> stripe_shift)[15:0]; stage 2 computes slice % num_cce_p (constant divisor), zero-extended.
- err_o=0 for all other regions.

## Timing
- Two registered stages, s1 and s2; latency exactly 2 cycles from acceptance to v_o with no stall.
- Full throughput: one request per cycle while yumi_i keeps pace.
- ready_o = ~s1_v | s1_advance; s1_advance = ~s2_v | yumi_i. Purely combinational from state and yumi_i; no combinational path paddr_v_i→ready_o.
- Stall: v_o, cce_id_o, err_o, paddr_o hold stable until yumi_i; s1 holds if s2 is stalled.
- Reset: s1_v=s2_v=0, v_o=0, ready_o=1 the cycle after reset deasserts, cce_id_o=0, err_o=0, paddr_o=0, config to reset values. Reset mid-operation discards all in-flight requests with no output.
- Simultaneous cfg write and request: request uses pre-write config.
- paddr_i exactly dram_base_p → dram; exactly coproc_base_p → coproc; dram_base_p−1 → local/host.

## Test plan
- Reset, then stream 0x80000000, 0x80000040, 0x80000080, 0x800000C0 back-to-back, yumi_i=1 -> v_o from cycle 2, IDs 0,1,2,3, no bubbles.
- num_cce_p=3, write stripe_shift=12, send 0x80000000, 0x80001000, 0x80002000, 0x80003000 -> IDs 0,1,2,0.
- Send 0x04_0000_0000 with acc_en=0 -> ID 0, err_o=1; write cfg1 = 0x8208 (en, lg=2, base=8), send 0x04_0000_0040, 0x04_0000_00C0 -> IDs 9, 11, err_o=0.
- Local 0x0230_0000 (dev 3, cce 2) -> ID 2; local 0x0010_0000 (dev 1) -> io_base_id_p=8; top did=1 -> 8.
- Hold yumi_i=0 5 cycles under continuous valid -> exactly 2 accepted, ready_o=0 from cycle 2, outputs stable; release -> in-order drain, no loss/duplication.
- Assert reset_i with both stages full -> next cycle v_o=0, ready_o=1, stripe_shift=6; cfg write of 3 in same cycle as request -> request uses old shift, later reads back clamped 6.
